// File: rtl/pool_2.sv
//------------------------------------------------------------------------------
// pool_2 -- second 2x2 stride-2 signed max-pooling stage.
//
// Walks the DEEP x IN_SIZE x IN_SIZE feature maps stored at SRC_BASE in the
// shared result BRAM and writes the DEEP x OUT_SIZE x OUT_SIZE pooled maps
// to DST_BASE in the same BRAM. Each window costs 22 enabled cycles:
// 1 check, 4 reads of 4 cycles each, 1 compare, and a 4-cycle write.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous, active-low reset
//   pool_2_en           run enable; all state frozen while low (except S_DONE)
//   result_bram_douta   BRAM read data (DATA_SIZE, signed)
//   result_bram_ena     BRAM enable
//   result_bram_wea     BRAM write enable
//   result_bram_addra   BRAM word address (15 bits)
//   result_bram_dina    BRAM write data (pooled maximum)
//   pool_2_finish       high in S_DONE until pool_2_en is dropped
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module pool_2 #(
    parameter int DEEP      = 50,
    parameter int IN_SIZE   = 8,
    parameter int OUT_SIZE  = 4,
    parameter int DATA_SIZE = 8,
    parameter int SRC_BASE  = 14400,
    parameter int DST_BASE  = 17600
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pool_2_en,
    input  logic [DATA_SIZE-1:0] result_bram_douta,
    output logic                 result_bram_ena,
    output logic                 result_bram_wea,
    output logic [14:0]          result_bram_addra,
    output logic [DATA_SIZE-1:0] result_bram_dina,
    output logic                 pool_2_finish
);

    localparam int CW = $clog2(DEEP + 1);
    localparam int PW = (OUT_SIZE > 2) ? $clog2(OUT_SIZE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LOAD,
        S_COMPARE,
        S_STORE,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CW-1:0]         r_c,     w_c_next;
    logic [PW-1:0]         r_r,     w_r_next;
    logic [PW-1:0]         r_col,   w_col_next;
    logic [1:0]            r_k,     w_k_next;
    logic [1:0]            r_p,     w_p_next;
    logic                  r_ena,   w_ena_next;
    logic                  r_wea,   w_wea_next;
    logic [14:0]           r_addra, w_addra_next;
    logic [DATA_SIZE-1:0]  r_dina,  w_dina_next;
    logic                  r_finish, w_finish_next;

    logic [DATA_SIZE-1:0]  r_window      [0:3];
    logic [DATA_SIZE-1:0]  w_window_next [0:3];
    logic [DATA_SIZE-1:0]  w_pair_max    [0:1];
    logic [DATA_SIZE-1:0]  w_max;
    logic                  w_capture;
    logic [14:0]           w_src_addr;
    logic [14:0]           w_dst_addr;

    // Window element k sits at row 2r + k/2, column 2col + k%2 of channel c.
    assign w_src_addr = 15'(SRC_BASE + int'(r_c) * IN_SIZE * IN_SIZE
                            + (2 * int'(r_r) + int'(r_k[1])) * IN_SIZE
                            + 2 * int'(r_col) + int'(r_k[0]));

    assign w_dst_addr = 15'(DST_BASE + int'(r_c) * OUT_SIZE * OUT_SIZE
                            + int'(r_r) * OUT_SIZE + int'(r_col));

    // Read data is taken on the fourth cycle of each element's read.
    assign w_capture = pool_2_en && (r_state == S_LOAD) && (r_p == 2'd3);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_window
            assign w_window_next[gi] = (w_capture && (r_k == 2'(gi)))
                                     ? result_bram_douta : r_window[gi];
        end
        // Two-level signed max tree; ties pick either operand (same bits).
        for (gi = 0; gi < 2; gi++) begin : g_pair
            assign w_pair_max[gi] =
                ($signed(r_window[2*gi]) >= $signed(r_window[2*gi+1]))
                ? r_window[2*gi] : r_window[2*gi+1];
        end
    endgenerate

    assign w_max = ($signed(w_pair_max[0]) >= $signed(w_pair_max[1]))
                 ? w_pair_max[0] : w_pair_max[1];

    always_comb begin
        w_state_next  = r_state;
        w_c_next      = r_c;
        w_r_next      = r_r;
        w_col_next    = r_col;
        w_k_next      = r_k;
        w_p_next      = r_p;
        w_ena_next    = r_ena;
        w_wea_next    = r_wea;
        w_addra_next  = r_addra;
        w_dina_next   = r_dina;
        w_finish_next = r_finish;

        if (pool_2_en) begin
            case (r_state)
                S_IDLE: begin
                    w_c_next      = '0;
                    w_r_next      = '0;
                    w_col_next    = '0;
                    w_k_next      = 2'd0;
                    w_p_next      = 2'd0;
                    w_finish_next = 1'b0;
                    w_ena_next    = 1'b0;
                    w_wea_next    = 1'b0;
                    w_state_next  = S_CHECK;
                end
                S_CHECK: begin
                    if (r_c == CW'(DEEP)) begin
                        w_ena_next    = 1'b0;
                        w_wea_next    = 1'b0;
                        w_finish_next = 1'b1;
                        w_state_next  = S_DONE;
                    end else begin
                        w_k_next     = 2'd0;
                        w_p_next     = 2'd0;
                        w_state_next = S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_wea_next = 1'b0;
                    case (r_p)
                        2'd0: begin
                            w_ena_next   = 1'b1;
                            w_addra_next = w_src_addr;
                            w_p_next     = 2'd1;
                        end
                        2'd3: begin
                            w_p_next = 2'd0;
                            if (r_k == 2'd3) begin
                                // Drop enable now so it is already low in S_COMPARE.
                                w_ena_next   = 1'b0;
                                w_state_next = S_COMPARE;
                            end else begin
                                w_k_next = r_k + 2'd1;
                            end
                        end
                        default: w_p_next = r_p + 2'd1;
                    endcase
                end
                S_COMPARE: begin
                    w_ena_next   = 1'b0;
                    w_wea_next   = 1'b0;
                    w_p_next     = 2'd0;
                    w_state_next = S_STORE;
                end
                S_STORE: begin
                    case (r_p)
                        2'd0: begin
                            w_ena_next   = 1'b1;
                            w_wea_next   = 1'b1;
                            w_addra_next = w_dst_addr;
                            w_dina_next  = w_max;
                            w_p_next     = 2'd1;
                        end
                        2'd3: begin
                            w_ena_next   = 1'b0;
                            w_wea_next   = 1'b0;
                            w_p_next     = 2'd0;
                            w_state_next = S_CHECK;
                            // Row-major walk, channel outermost.
                            if (r_col == PW'(OUT_SIZE - 1)) begin
                                w_col_next = '0;
                                if (r_r == PW'(OUT_SIZE - 1)) begin
                                    w_r_next = '0;
                                    w_c_next = r_c + CW'(1);
                                end else begin
                                    w_r_next = r_r + PW'(1);
                                end
                            end else begin
                                w_col_next = r_col + PW'(1);
                            end
                        end
                        default: w_p_next = r_p + 2'd1;
                    endcase
                end
                S_DONE: begin
                    w_finish_next = 1'b1;
                end
                default: w_state_next = S_IDLE;
            endcase
        end else if (r_state == S_DONE) begin
            // Dropping the enable after completion re-arms for a fresh run.
            w_finish_next = 1'b0;
            w_state_next  = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_c      <= '0;
            r_r      <= '0;
            r_col    <= '0;
            r_k      <= 2'd0;
            r_p      <= 2'd0;
            r_ena    <= 1'b0;
            r_wea    <= 1'b0;
            r_addra  <= '0;
            r_dina   <= '0;
            r_finish <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_window[i] <= '0;
            end
        end else begin
            r_state  <= w_state_next;
            r_c      <= w_c_next;
            r_r      <= w_r_next;
            r_col    <= w_col_next;
            r_k      <= w_k_next;
            r_p      <= w_p_next;
            r_ena    <= w_ena_next;
            r_wea    <= w_wea_next;
            r_addra  <= w_addra_next;
            r_dina   <= w_dina_next;
            r_finish <= w_finish_next;
            for (int i = 0; i < 4; i++) begin
                r_window[i] <= w_window_next[i];
            end
        end
    end

    assign result_bram_ena   = r_ena;
    assign result_bram_wea   = r_wea;
    assign result_bram_addra = r_addra;
    assign result_bram_dina  = r_dina;
    assign pool_2_finish     = r_finish;

endmodule

// File: tb/tb_pool_2.sv
`timescale 1ns/1ps

module tb_pool_2;

    localparam int SRC  = 14400;
    localparam int DST  = 17600;
    localparam int NIN  = 3200;
    localparam int NOUT = 800;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  douta;
    logic        ena;
    logic        wea;
    logic [14:0] addra;
    logic [7:0]  dina;
    logic        finish;

    always #5 clk = ~clk;

    pool_2 dut (
        .clk               (clk),
        .rst               (rst),
        .pool_2_en         (en),
        .result_bram_douta (douta),
        .result_bram_ena   (ena),
        .result_bram_wea   (wea),
        .result_bram_addra (addra),
        .result_bram_dina  (dina),
        .pool_2_finish     (finish)
    );

    // Source image (read-only) and BRAM write storage.
    logic [7:0] img  [0:NIN-1];
    logic [7:0] mem  [0:32767];
    logic [7:0] snap [0:NOUT-1];
    logic [7:0] pipe;

    // BRAM model: two-stage read latency, write when ena & wea.
    always @(posedge clk) begin
        if (ena) begin
            if (wea) mem[addra] <= dina;
            if (int'(addra) >= SRC && int'(addra) < SRC + NIN)
                pipe <= img[int'(addra) - SRC];
            else
                pipe <= mem[addra];
        end
        douta <= pipe;
    end

    typedef struct {
        logic [14:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t         sb [$];
    logic [14:0] rd_log [$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    int          edge_cnt = 0;
    logic        prev_wea = 1'b0;
    logic        prev_ena = 1'b0;
    logic [14:0] prev_addr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_max(input int c, input int r, input int col);
        int base;
        logic signed [7:0] v [0:3];
        logic signed [7:0] m;
        base = c * 64 + 2 * r * 8 + 2 * col;
        v[0] = img[base];
        v[1] = img[base + 1];
        v[2] = img[base + 8];
        v[3] = img[base + 9];
        m = v[0];
        for (int i = 1; i < 4; i++) if (v[i] > m) m = v[i];
        return m;
    endfunction

    task automatic fill_sb();
        wr_t e;
        sb.delete();
        for (int c = 0; c < 50; c++)
            for (int r = 0; r < 4; r++)
                for (int col = 0; col < 4; col++) begin
                    e.a = 15'(DST + c * 16 + r * 4 + col);
                    e.d = ref_max(c, r, col);
                    sb.push_back(e);
                end
    endtask

    // Advance one edge, then observe outputs away from the edge.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        edge_cnt++;
        if (wea && !prev_wea) begin
            n_writes++;
            check("wr_range", 32'(int'(addra) >= DST && int'(addra) < DST + NOUT), 32'd1);
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", 32'(addra), 32'(e.a));
                check("wr_data", 32'(dina), 32'(e.d));
            end
        end
        if (ena && !wea && (!prev_ena || prev_wea || addra != prev_addr) && rd_log.size() < 8)
            rd_log.push_back(addra);
        prev_wea  = wea;
        prev_ena  = ena;
        prev_addr = addra;
    endtask

    task automatic wait_finish(input int limit);
        int i;
        i = 0;
        while (!finish && i < limit) begin
            tick();
            i++;
        end
        check("finish_timeout", 32'(finish), 32'd1);
    endtask

    task automatic check_first_reads();
        logic [14:0] exp_rd [0:3];
        exp_rd[0] = 15'd14400;
        exp_rd[1] = 15'd14401;
        exp_rd[2] = 15'd14408;
        exp_rd[3] = 15'd14409;
        check("rd_log_size", 32'(rd_log.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++)
            if (i < rd_log.size()) check("rd_addr", 32'(rd_log[i]), 32'(exp_rd[i]));
    endtask

    initial begin
        logic [14:0] fr_addr;
        logic [7:0]  fr_dina;
        int          bad;

        // Source image: ramp, with two crafted windows at the start.
        for (int i = 0; i < NIN; i++) img[i] = 8'(i % 256);
        img[0]  = 8'h05; img[1]  = 8'hFA; img[8]  = 8'h7F; img[9]  = 8'h80;
        img[2]  = 8'h80; img[3]  = 8'hFF; img[10] = 8'h90; img[11] = 8'hFE;

        // ---- reset held with enable toggling ----
        rst = 1'b0;
        en  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            en = ~en;
            tick();
            check("reset_outputs", 32'({ena, wea, addra, dina, finish}), 32'd0);
        end
        en  = 1'b0;
        tick();
        rst = 1'b1;

        // ---- run 1: uninterrupted ----
        fill_sb();
        rd_log.delete();
        n_writes = 0;
        edge_cnt = 0;
        en = 1'b1;
        wait_finish(20000);
        $display("run1: finish at edge %0d, writes %0d", edge_cnt, n_writes);
        check("run1_finish_edge", 32'(edge_cnt), 32'd17602);
        check("run1_writes", 32'(n_writes), 32'd800);
        check("run1_sb_empty", 32'(sb.size()), 32'd0);
        check_first_reads();
        check("win0_max", 32'(mem[DST]), 32'h7F);
        check("win_neg_max", 32'(mem[DST + 1]), 32'hFF);
        for (int i = 0; i < NOUT; i++) snap[i] = mem[DST + i];
        for (int i = 0; i < 3; i++) begin
            tick();
            check("finish_held", 32'(finish), 32'd1);
        end
        en = 1'b0;
        tick();
        check("finish_clear", 32'(finish), 32'd0);

        // ---- run 2: freezes mid-load and mid-store ----
        fill_sb();
        rd_log.delete();
        n_writes = 0;
        edge_cnt = 0;
        en = 1'b1;
        repeat (3) tick();
        check("load_ena", 32'(ena), 32'd1);
        check("load_addr", 32'(addra), 32'd14400);
        en = 1'b0;
        repeat (10) tick();
        check("frz_load_ena", 32'(ena), 32'd1);
        check("frz_load_wea", 32'(wea), 32'd0);
        check("frz_load_addr", 32'(addra), 32'd14400);
        en = 1'b1;
        while (edge_cnt < 140) tick();
        check("store_wea", 32'(wea), 32'd1);
        check("store_addr", 32'(addra), 32'(DST + 5));
        check("store_dina", 32'(dina), 32'(ref_max(0, 1, 1)));
        fr_addr = addra;
        fr_dina = dina;
        en = 1'b0;
        repeat (10) tick();
        check("frz_store_wea", 32'(wea), 32'd1);
        check("frz_store_addr", 32'(addra), 32'(fr_addr));
        check("frz_store_dina", 32'(dina), 32'(fr_dina));
        en = 1'b1;
        wait_finish(20000);
        $display("run2: finish at edge %0d, writes %0d", edge_cnt, n_writes);
        check("run2_finish_edge", 32'(edge_cnt), 32'd17622);
        check("run2_writes", 32'(n_writes), 32'd800);
        check("run2_sb_empty", 32'(sb.size()), 32'd0);
        check_first_reads();
        bad = 0;
        for (int i = 0; i < NOUT; i++) if (mem[DST + i] !== snap[i]) bad++;
        check("run2_mem_match", 32'(bad), 32'd0);
        en = 1'b0;
        tick();
        check("finish_clear2", 32'(finish), 32'd0);

        // ---- run 3: asynchronous reset during a store ----
        fill_sb();
        edge_cnt = 0;
        en = 1'b1;
        repeat (20) tick();
        check("pre_rst_wea", 32'(wea), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_outs", 32'({ena, wea, addra, finish}), 32'd0);
        $display("run3: reset asserted during store");
        repeat (2) tick();
        check("rst_hold_outs", 32'({ena, wea, addra, dina, finish}), 32'd0);
        fill_sb();
        rd_log.delete();
        n_writes = 0;
        edge_cnt = 0;
        rst = 1'b1;
        wait_finish(20000);
        $display("run3: finish at edge %0d, writes %0d", edge_cnt, n_writes);
        check("run3_finish_edge", 32'(edge_cnt), 32'd17602);
        check("run3_writes", 32'(n_writes), 32'd800);
        check("run3_sb_empty", 32'(sb.size()), 32'd0);
        check_first_reads();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("finish_held3", 32'(finish), 32'd1);
        end
        en = 1'b0;
        tick();
        check("finish_clear3", 32'(finish), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
